// File: rtl/sm_dot_mac.sv
// rtl/sm_dot_mac.sv - pipelined sign-magnitude multiply-accumulate producing saturated dot products
//
// Consumes one sign-magnitude operand pair per cycle. Every DOT_LEN accepted
// pairs it emits one sign-magnitude dot product. A result whose magnitude does
// not fit in ACC_WIDTH bits is clamped to all ones and flagged with overflow.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand pair present on dataa/datab
//   in_ready   pair can be accepted this cycle
//   dataa      operand a, {sign, magnitude[WIDTHA-2:0]}
//   datab      operand b, {sign, magnitude[WIDTHB-2:0]}
//   out_valid  result/overflow hold a finished dot product
//   out_ready  consumer takes the result this cycle
//   result     {sign, magnitude[ACC_WIDTH-1:0]} dot product
//   overflow   result magnitude was saturated

module sm_dot_mac #(
    parameter int WIDTHA    = 9,
    parameter int WIDTHB    = 8,
    parameter int DOT_LEN   = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTHA-1:0]    dataa,
    input  logic [WIDTHB-1:0]    datab,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH:0]   result,
    output logic                 overflow
);

    localparam int PW = WIDTHA + WIDTHB - 2;
    // Wide enough to hold DOT_LEN worst-case products without wrapping.
    localparam int AW = PW + 1 + $clog2(DOT_LEN);
    localparam int CW = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
    // Magnitude is widened so the saturation test always has at least one
    // bit above the ACC_WIDTH result field to look at.
    localparam int MW = (AW > ACC_WIDTH) ? AW : ACC_WIDTH + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DOT_LEN - 1);

    logic                 advance;
    logic [CW-1:0]        cnt;

    logic [PW-1:0]        prod_mag;
    logic                 prod_sign;
    logic signed [PW:0]   prod_tc;

    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    logic signed [PW:0]   s1_prod;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] sum;
    logic                 sum_neg;
    logic [AW-1:0]        sum_abs;
    logic [MW-1:0]        abs_ext;
    logic                 sat;

    // The whole pipe freezes only when a held result is not being taken.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // Stage 1 input: sign-magnitude product turned into two's complement.
    // A zero magnitude with sign 1 negates to zero, so negative zeros vanish here.
    assign prod_mag  = PW'(dataa[WIDTHA-2:0]) * PW'(datab[WIDTHB-2:0]);
    assign prod_sign = dataa[WIDTHA-1] ^ datab[WIDTHB-1];
    assign prod_tc   = prod_sign ? -$signed({1'b0, prod_mag}) : $signed({1'b0, prod_mag});

    // Stage 2: the running sum is formed combinationally so the output
    // register can capture the final sum on the same edge as the accumulator.
    assign prod_ext = AW'(s1_prod);
    assign sum      = s1_first ? prod_ext : acc + prod_ext;
    assign sum_neg  = sum[AW-1];
    assign sum_abs  = sum_neg ? AW'(-sum) : AW'(sum);
    assign abs_ext  = MW'(sum_abs);
    assign sat      = |abs_ext[MW-1:ACC_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_prod   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_first <= (cnt == '0);
            s1_last  <= (cnt == LAST_CNT);
            s1_prod  <= prod_tc;
            if (in_valid) begin
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            end
            if (s1_valid) begin
                acc <= sum;
            end
            // advance implies any held result is being taken, so the output
            // either reloads with the new sum or empties.
            if (s1_valid && s1_last) begin
                out_valid <= 1'b1;
                result    <= {sum_neg, sat ? {ACC_WIDTH{1'b1}} : abs_ext[ACC_WIDTH-1:0]};
                overflow  <= sat;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
